ysyx_22051013_ctrl_fsm: RTL
===========================

Name: ysyx_22051013_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the ysyx_22051013 RV64 core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Handshakes with the instruction and data memory ports, samples the decoder's classification outputs, and issues the write enables for the IR, PC and register file.
- Halts on ebreak or on a memory timeout.

Parameters:
- MEM_TIMEOUT, 256: maximum cycles to wait for imem_ack/dmem_ack before an error halt; 0 disables the timeout.
- TO_W, 9: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high (compared against ysyx_22051013_RSTABLE)
- start  in  1  leave IDLE and begin fetching
- imem_req  out  1  instruction fetch request, held until ack
- imem_ack  in  1  fetch data valid this cycle
- ir_we  out  1  latch instruction register
- dec_is_load  in  1  decoder: load
- dec_is_store  in  1  decoder: store (e.g. sd)
- dec_jump  in  1  decoder: jal/jalr
- dec_rd_wen  in  1  decoder: writes rd (addi/auipc/lui/jal/jalr/load)
- dec_ebreak  in  1  decoder: ebreak
- dmem_req  out  1  data memory request, held until ack
- dmem_we  out  1  data memory write (valid with dmem_req)
- dmem_ack  in  1  data memory done
- pc_we  out  1  update PC
- pc_sel  out  1  0 = pc+4, 1 = jump target
- rf_we  out  1  register file write
- halt  out  1  core halted
- err  out  1  halted due to timeout
- state  out  3  current state, for debug

Behaviour:
- Reset (rst high at a posedge): state=IDLE, timeout counter=0, latched decode flags=0.
  - All outputs 0.
  - rst wins over every other event, including mid-handshake; any in-flight request is dropped.
- IDLE: all outputs 0. start=1 moves to FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ack=1 → ir_we=1 the same cycle; next state DECODE.
  - An ack in the first FETCH cycle is legal, giving a 1-cycle fetch.
- DECODE: register dec_* into internal flags at the end of the cycle.
  - dec_ebreak=1 → HALT; pc_we is never asserted for the ebreak.
  - Otherwise → EXEC.
- EXEC: one cycle for the ALU.
  - Next state is MEM if the latched is_load or is_store is set, else WB.
- MEM: dmem_req=1, dmem_we=latched is_store.
  - dmem_ack=1 → WB next cycle.
- WB: pc_we=1, pc_sel=latched jump, rf_we=latched rd_wen & ~latched is_store; next state FETCH.
  - All three are single-cycle pulses.
- HALT: halt=1 held until rst. start and acks are ignored. err holds its value.
- Latency:
  - Non-memory instruction with immediate ack: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles minimum.
- Timeout (MEM_TIMEOUT≠0):
  - Counter clears on entering FETCH or MEM and increments each cycle in that state without an ack.
  - When the count reaches MEM_TIMEOUT-1 with no ack: next state HALT, err=1.
  - An ack on that same cycle wins; no error.
- Acks arriving outside FETCH/MEM are ignored. dec_* inputs are don't-care outside DECODE.
- Decoder flags that are mutually exclusive but arrive simultaneously: priority is ebreak > load/store > others.
- dmem_req and imem_req are never high in the same cycle.
- state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; the value 7 recovers to IDLE.

Optional Feature:
- Macro YSYX_22051013_PERF_CNT_EN.
- Defined: adds two outputs, cycle_cnt (64) and instret_cnt (64), both reset to 0.
  - cycle_cnt increments every cycle the state is neither IDLE nor HALT.
  - instret_cnt increments on each WB cycle.
  - Both wrap modulo 2^64.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared define file (alongside RSTABLE): state encoding constants and the state width (3).
- One natural sub-module: ysyx_22051013_wait_timer.
  - Clearable up-counter with an expire flag at MEM_TIMEOUT-1, and a disable when the parameter is 0.
  - Instantiated once and shared by FETCH and MEM.

Test Plan:
- rst=1 then start=1 with imem_ack tied to 1 and an addi in the decoder → state sequence 1,2,3,5,1; pc_we=1 and rf_we=1 exactly in the WB cycle; pc_sel=0.
- Store with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=1; rf_we=0 in WB; total 8 cycles from FETCH to the next FETCH.
- jal with dec_jump=1 → WB asserts pc_sel=1, pc_we=1, rf_we=1.
- ebreak (dec_ebreak=1) → HALT after DECODE; halt=1, pc_we never pulses, err=0; a later start has no effect until rst.
- MEM_TIMEOUT=4 with imem_ack held 0 → HALT entered after 4 FETCH cycles with err=1; repeat with the ack on cycle 4 → DECODE, err=0.
- rst asserted during MEM with dmem_req=1 → next cycle state=IDLE and all outputs 0; with PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/ysyx_22051013_ctrl_fsm_pkg.sv
// Shared definitions for the ysyx_22051013 control sequencer: reset polarity,
// state width and the state encoding exposed on the debug port.
package ysyx_22051013_ctrl_fsm_pkg;

  localparam logic ysyx_22051013_RSTABLE = 1'b1;
  localparam int   STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } ctrl_state_e;

  // States that sit on a memory handshake and are covered by the wait timer.
  function automatic logic is_mem_wait(ctrl_state_e s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/ysyx_22051013_wait_timer.sv
// Handshake wait timer: counts cycles spent waiting without an ack and flags
// expiry on the last allowed cycle. MEM_TIMEOUT of 0 disables expiry.
module ysyx_22051013_wait_timer
  import ysyx_22051013_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int TO_W        = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic expire
);

  localparam logic            ENABLED = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] LIMIT   = TO_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // Leaving the wait state clears the count, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      count <= '0;
    end else if (!waiting) begin
      count <= '0;
    end else if (!ack) begin
      count <= count + 1'b1;
    end
  end

  // An ack on the final cycle takes precedence over expiry.
  assign expire = ENABLED && waiting && !ack && (count == LIMIT);

endmodule

// File: rtl/ysyx_22051013_ctrl_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the RV64 core.
// Optional perf counters are built when YSYX_22051013_PERF_CNT_EN is defined.
module ysyx_22051013_ctrl_fsm
  import ysyx_22051013_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int TO_W        = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_jump,
  input  logic        dec_rd_wen,
  input  logic        dec_ebreak,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state
`ifdef YSYX_22051013_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  logic        l_load, l_store, l_jump, l_rd_wen;
  logic        err_q;
  logic        to_waiting, to_ack, to_expire;

  // Handshake protocol: a request is held high until the cycle its ack is
  // seen; that cycle completes the transfer and the request drops next cycle.
  assign to_waiting = is_mem_wait(state_q);
  assign to_ack     = (state_q == S_FETCH) ? imem_ack : dmem_ack;

  ysyx_22051013_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (to_waiting),
    .ack     (to_ack),
    .expire  (to_expire)
  );

  always_ff @(posedge clk) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      state_q  <= S_IDLE;
      l_load   <= 1'b0;
      l_store  <= 1'b0;
      l_jump   <= 1'b0;
      l_rd_wen <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        l_load   <= dec_is_load;
        l_store  <= dec_is_store;
        l_jump   <= dec_jump;
        l_rd_wen <= dec_rd_wen;
      end
      if (to_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    halt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_expire) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        // ebreak outranks every other decoder flag.
        state_d = dec_ebreak ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = (l_load || l_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = l_store;
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (to_expire) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        pc_sel  = l_jump;
        rf_we   = l_rd_wen && !l_store;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err   = err_q;
  assign state = state_q;

`ifdef YSYX_22051013_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
      if (state_q == S_WB) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule
